// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment order everywhere is {G,F,E,D,C,B,A}, active-high in this package.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark (active-high sense; callers apply polarity).
  localparam seg_t SEG_OFF = 7'b0000000;

  localparam seg_t SEG_HEX_PATTERNS [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Index width that stays at least one bit for a single-digit display.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Load port of the scan driver: a packed hex word plus per-digit dp/blank
// masks, transferred when load_valid && load_ready.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic [NUM_DIGITS-1:0]   load_blank;

  modport master (output load_valid, load_data, load_dp, load_blank,
                  input  load_ready);
  modport slave  (input  load_valid, load_data, load_dp, load_blank,
                  output load_ready);
endinterface

// File: rtl/seven_seg_scan_driver_hex_lut.sv
// Hex nibble to seven-segment pattern, with output polarity applied.
module seven_seg_hex_lut
  import seven_seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);
  assign o_seg = SEG_ACTIVE_LOW ? ~SEG_HEX_PATTERNS[i_nibble]
                                :  SEG_HEX_PATTERNS[i_nibble];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver.
// A loaded word sits in a pending buffer and moves to the display registers
// only at frame end (or at once while disabled), so a frame never tears.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W         = idx_width(NUM_DIGITS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  seven_seg_scan_driver_if.slave load_if,
  output seg_t                   o_seg,
  output logic                   o_dp,
  output logic [NUM_DIGITS-1:0]  o_an,
  output logic [IDX_W-1:0]       o_digit_idx
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam seg_t                  SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [DIV_W-1:0]      r_div;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_pend_vld;
  logic [DW-1:0]         r_pend_data, r_disp_data;
  logic [NUM_DIGITS-1:0] r_pend_dp, r_pend_blank, r_disp_dp, r_disp_blank;

  logic                  w_slot_end, w_frame_end, w_load, w_apply, w_lit;
  logic [NUM_DIGITS-1:0] w_blank_eff, w_an;
  logic [3:0]            w_nib;
  seg_t                  w_seg;

  assign w_slot_end  = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign load_if.load_ready = !r_pend_vld;
  assign w_load  = load_if.load_valid && !r_pend_vld;
  assign w_apply = r_pend_vld && (w_frame_end || !i_enable);

  // Slot/digit counters; disable parks the scan at digit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Double buffer: accept into pending, promote to display at frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_vld   <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
    end else if (w_apply) begin
      r_pend_vld   <= 1'b0;
      r_disp_data  <= r_pend_data;
      r_disp_dp    <= r_pend_dp;
      r_disp_blank <= r_pend_blank;
    end else if (w_load) begin
      r_pend_vld   <= 1'b1;
      r_pend_data  <= load_if.load_data;
      r_pend_dp    <= load_if.load_dp;
      r_pend_blank <= load_if.load_blank;
    end
  end

  // Effective per-digit blank mask seen by the scanner.
  always_comb begin
    w_blank_eff = r_disp_blank;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin
      logic w_upper_zero;
      w_upper_zero = 1'b1;
      // Walk down from the top digit; digit 0 is never suppressed.
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        w_upper_zero = w_upper_zero && (r_disp_data[4*i +: 4] == 4'h0);
        if (w_upper_zero) w_blank_eff[i] = 1'b1;
      end
    end
`endif
  end

  assign w_nib = r_disp_data[{r_idx, 2'b00} +: 4];

  seven_seg_hex_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lut (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

  // Anode vector: only the current digit, after the anti-ghost window.
  always_comb begin
    w_lit        = (r_div >= DIV_W'(BLANK_CYCLES)) && !w_blank_eff[r_idx];
    w_an         = AN_IDLE;
    w_an[r_idx]  = w_lit ^ AN_ACTIVE_LOW;
  end

  // Registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      o_seg       <= SEG_IDLE;
      o_dp        <= SEG_ACTIVE_LOW;
      o_an        <= AN_IDLE;
      o_digit_idx <= '0;
    end else begin
      o_seg       <= w_seg;
      o_dp        <= r_disp_dp[r_idx] ^ SEG_ACTIVE_LOW;
      o_an        <= w_an;
      o_digit_idx <= r_idx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (4 digits, 4-cycle slots,
// 1 blank cycle, active-low segments and anodes).
module tb_seven_seg_scan_driver;
  import seven_seg_pkg::*;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int FRAME = ND * SD;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  seg_t       seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] didx;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) lif ();

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BL),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .load_if(lif.slave),
    .o_seg(seg), .o_dp(dp), .o_an(an), .o_digit_idx(didx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int ncmp = 0;
  int nfail = 0;

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  // Reference model: frame position as plain modular arithmetic, a single
  // pending word and the displayed word.
  initial begin
    int pos;
    bit pend;
    logic [15:0] pd, dd;
    logic [3:0]  pdp, pbl, ddp, dbl;
    pos = 0; pend = 0; pd = '0; dd = '0; pdp = '0; pbl = '0; ddp = '0; dbl = '0;
    forever begin
      exp_t e;
      bit load, apply;
      @(posedge clk);
      e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, idx: 2'd0, ready: 1'b1};
      if (rst) begin
        pos = 0; pend = 0; dd = '0; ddp = '0; dbl = '0;
      end else begin
        if (en) begin
          int ix, d;
          bit blanked;
          ix = pos / SD;
          d  = pos % SD;
          blanked = dbl[ix] || (LZ && ix > 0 && ((dd >> (4 * ix)) == 16'h0));
          e.seg = ~hexpat(dd[4*ix +: 4]);
          e.dp  = ~ddp[ix];
          e.idx = 2'(ix);
          if (d >= BL && !blanked) e.an[ix] = 1'b0;
        end
        load  = lif.load_valid && !pend;
        apply = pend && (!en || pos == FRAME - 1);
        if (apply) begin
          dd = pd; ddp = pdp; dbl = pbl; pend = 0;
        end
        if (load) begin
          pd = lif.load_data; pdp = lif.load_dp; pbl = lif.load_blank; pend = 1;
        end
        pos = en ? (pos + 1) % FRAME : 0;
      end
      e.ready = !pend;
      exp_q.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents a pin state; compare against model.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        ncmp++;
        if (seg !== e.seg || dp !== e.dp || an !== e.an || didx !== e.idx ||
            lif.load_ready !== e.ready) begin
          nfail++;
          $display("FAIL pins t=%0t: got seg=%b dp=%b an=%b idx=%0d rdy=%b, want seg=%b dp=%b an=%b idx=%0d rdy=%b",
                   $time, seg, dp, an, didx, lif.load_ready,
                   e.seg, e.dp, e.an, e.idx, e.ready);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a word and hold valid until the handshake completes; valid is
  // left asserted so callers can chain words back to back.
  task automatic send(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bit done;
    done = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_dp    = p;
    lif.load_blank = b;
    for (int k = 0; k < 100 && !done; k++) begin
      if (lif.load_ready) done = 1;
      @(negedge clk);
    end
    if (!done) begin
      ncmp++;
      nfail++;
      $display("FAIL handshake: load_ready stayed %b for 100 cycles, want 1", lif.load_ready);
    end
  endtask

  task automatic drop();
    lif.load_valid = 1'b0;
  endtask

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_dp    = '0;
    lif.load_blank = '0;
    idle(3);
    rst = 1'b0;
    en  = 1'b1;
    idle(20);

    // Single word, then two words back to back with valid held.
    send(16'h1230, 4'h0, 4'h0); drop(); idle(40);
    send(16'hABCD, 4'h0, 4'h0);
    send(16'h4567, 4'h0, 4'h0); drop(); idle(40);

    // Blank mask and decimal point.
    send(16'h9876, 4'b0001, 4'b0100); drop(); idle(40);

    // Disable mid-frame with a load landing while disabled.
    idle(9);
    en = 1'b0;
    idle(2);
    send(16'hE0F1, 4'b1010, 4'h0); drop(); idle(4);
    en = 1'b1;
    idle(36);

    // Leading-zero cases.
    send(16'h0005, 4'h0, 4'h0); drop(); idle(36);
    send(16'h0000, 4'h0, 4'h0); drop(); idle(36);
    send(16'h00A0, 4'b0010, 4'h0); drop(); idle(36);

    // Mid-operation reset with a pending word outstanding.
    send(16'h7777, 4'hF, 4'h0); drop();
    rst = 1'b1; idle(2); rst = 1'b0; idle(20);

    // Randomised traffic.
    for (int c = 0; c < 2500; c++) begin
      lif.load_valid = ($urandom_range(0, 3) == 0);
      lif.load_data  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lif.load_data[15:8] = 8'h00;
      lif.load_dp    = 4'($urandom);
      lif.load_blank = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 39) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    drop();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
